// File: rtl/soc_pkg.sv
// Shared constants, types and address helpers for the SoC wrapper.
// The RAM sits at RAM_BASE and is organised as 128-bit lines.
package soc_pkg;

    localparam logic [31:0] RAM_BASE  = 32'h8000_0000;
    localparam int          RAM_LINES = 4096;
    localparam logic [31:0] RESET_PC  = 32'h8000_0000;
    localparam int          WORD_W    = 2;

    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        logic valid;
        logic err;
    } rsp_t;

    function automatic logic in_range(
        input logic [31:0] addr,
        input logic [31:0] base,
        input int unsigned lines
    );
        logic [31:0] off;
        off = addr - base;
        return off < (lines << 4);
    endfunction

endpackage

// File: rtl/my_wrapper_soc_if.sv
// Core-side instruction and data memory ports of the SoC wrapper.
// master = the core, slave = the wrapper.
interface my_wrapper_soc_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_valid;
    logic        imem_err;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_valid;
    logic        dmem_err;

    modport master (
        output imem_req, imem_addr,
        output dmem_req, dmem_we, dmem_addr,
        output dmem_wstrb, dmem_wdata,
        input  imem_rdata, imem_valid, imem_err,
        input  dmem_rdata, dmem_valid, dmem_err
    );

    modport slave (
        input  imem_req, imem_addr,
        input  dmem_req, dmem_we, dmem_addr,
        input  dmem_wstrb, dmem_wdata,
        output imem_rdata, imem_valid, imem_err,
        output dmem_rdata, dmem_valid, dmem_err
    );

endinterface

// File: rtl/my_wrapper_soc_line_ram.sv
// True dual-port 128-bit line RAM with registered 32-bit word reads.
// Port A reads only; port B reads or byte-strobe writes.
module line_ram
    import soc_pkg::*;
#(
    parameter int LINES = 4096,
    parameter int LW    = $clog2(LINES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_en,
    input  logic [LW-1:0] a_line,
    input  word_t         a_word,
    output logic [31:0]   a_rdata,
    input  logic          b_en,
    input  logic          b_we,
    input  logic [LW-1:0] b_line,
    input  word_t         b_word,
    input  logic [3:0]    b_strb,
    input  logic [31:0]   b_wdata,
    output logic [31:0]   b_rdata
);

    logic [127:0] data [0:LINES-1];

    // Contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (b_en && b_we) begin
            for (int i = 0; i < 4; i++) begin
                if (b_strb[i])
                    data[b_line][{b_word, 5'd0} + 7'(8*i) +: 8]
                        <= b_wdata[8*i +: 8];
            end
        end
    end

    // Reads sample the array before this edge's write lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_rdata <= '0;
            b_rdata <= '0;
        end else begin
            if (a_en)
                a_rdata <= data[a_line][{a_word, 5'd0} +: 32];
            if (b_en)
                b_rdata <= data[b_line][{b_word, 5'd0} +: 32];
        end
    end

endmodule

// File: rtl/my_wrapper_soc.sv
// SoC wrapper: line RAM, fetch/load-store port adapters and decode.
// Out-of-range accesses answer with err and zero data.
module my_wrapper_soc
    import soc_pkg::*;
#(
    parameter logic [31:0] RAM_BASE  = soc_pkg::RAM_BASE,
    parameter int          RAM_LINES = soc_pkg::RAM_LINES
) (
    input  logic            CLK,
    input  logic            RST,
    my_wrapper_soc_if.slave cpu
);

    localparam int LW = $clog2(RAM_LINES);

    logic [31:0]   i_off;
    logic [31:0]   d_off;
    logic          i_hit;
    logic          d_hit;
    logic [LW-1:0] i_line;
    logic [LW-1:0] d_line;
    word_t         i_word;
    word_t         d_word;
    logic [31:0]   i_word_q;
    logic [31:0]   d_word_q;
    rsp_t          i_rsp;
    rsp_t          d_rsp;

    assign i_off  = cpu.imem_addr - RAM_BASE;
    assign d_off  = cpu.dmem_addr - RAM_BASE;
    assign i_hit  = in_range(cpu.imem_addr, RAM_BASE, RAM_LINES);
    assign d_hit  = in_range(cpu.dmem_addr, RAM_BASE, RAM_LINES);
    assign i_line = LW'(i_off >> 4);
    assign d_line = LW'(d_off >> 4);
    assign i_word = WORD_W'(i_off >> 2);
    assign d_word = WORD_W'(d_off >> 2);

    line_ram #(
        .LINES (RAM_LINES),
        .LW    (LW)
    ) ram (
        .clk     (CLK),
        .rst     (RST),
        .a_en    (cpu.imem_req & i_hit),
        .a_line  (i_line),
        .a_word  (i_word),
        .a_rdata (i_word_q),
        .b_en    (cpu.dmem_req & d_hit),
        .b_we    (cpu.dmem_we),
        .b_line  (d_line),
        .b_word  (d_word),
        .b_strb  (cpu.dmem_wstrb),
        .b_wdata (cpu.dmem_wdata),
        .b_rdata (d_word_q)
    );

    // Reset cancels any response still in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            i_rsp <= '0;
            d_rsp <= '0;
        end else begin
            i_rsp.valid <= cpu.imem_req;
            i_rsp.err   <= cpu.imem_req & ~i_hit;
            d_rsp.valid <= cpu.dmem_req;
            d_rsp.err   <= cpu.dmem_req & ~d_hit;
        end
    end

    assign cpu.imem_valid = i_rsp.valid;
    assign cpu.imem_err   = i_rsp.err;
    assign cpu.imem_rdata =
        (i_rsp.valid && !i_rsp.err) ? i_word_q : '0;

    assign cpu.dmem_valid = d_rsp.valid;
    assign cpu.dmem_err   = d_rsp.err;
    assign cpu.dmem_rdata =
        (d_rsp.valid && !d_rsp.err) ? d_word_q : '0;

endmodule

// File: tb/tb_my_wrapper_soc.sv
// Bench for my_wrapper_soc: stands in for the core on both ports.
// Expected responses are queued at drive time and popped on valid.
module tb_my_wrapper_soc;
    import soc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    my_wrapper_soc_if bus();

    my_wrapper_soc dut (
        .CLK (clk),
        .RST (rst),
        .cpu (bus)
    );

    typedef struct {
        bit          ireq;
        logic [31:0] iaddr;
        logic [31:0] irdata;
        bit          ierr;
        bit          dreq;
        bit          dwe;
        logic [31:0] daddr;
        logic [3:0]  dstrb;
        logic [31:0] dwdata;
        logic [31:0] drdata;
        bit          derr;
        bit          dchk;
        string       name;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        bit          err;
        bit          chk;
        string       name;
    } exp_t;

    localparam logic [127:0] L0 =
        128'h340fe0f3_340f9073_0def8f93_0badcfb7;
    localparam logic [127:0] L4 = 128'h11223344;
    localparam logic [127:0] L8 =
        128'h44444444_33333333_22222222_01010101;
    localparam logic [127:0] L264  = 128'hABABABAB;
    localparam logic [127:0] LLAST = {32'hCAFEF00D, 96'h0};

    exp_t iq[$];
    exp_t dq[$];
    vec_t tbl[15];
    int   nvec = 0;
    int   nmis = 0;

    task automatic check(string name, logic [31:0] act,
                         logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check128(string name, logic [127:0] act,
                            logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        bus.imem_req   = v.ireq;
        bus.imem_addr  = v.iaddr;
        bus.dmem_req   = v.dreq;
        bus.dmem_we    = v.dwe;
        bus.dmem_addr  = v.daddr;
        bus.dmem_wstrb = v.dstrb;
        bus.dmem_wdata = v.dwdata;
        if (v.ireq)
            iq.push_back('{v.irdata, v.ierr, 1'b1, v.name});
        if (v.dreq)
            dq.push_back('{v.drdata, v.derr, v.dchk, v.name});
    endtask

    task automatic idle();
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we  = 1'b0;
    endtask

    // Response monitor: every valid must match the oldest expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst) begin
            if (bus.imem_valid === 1'b1) begin
                if (iq.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL imem_spurious: got valid=1 want 0");
                end else begin
                    e = iq.pop_front();
                    check({e.name, "_irdata"}, bus.imem_rdata, e.rdata);
                    check({e.name, "_ierr"}, 32'(bus.imem_err),
                          32'(e.err));
                end
            end
            if (bus.dmem_valid === 1'b1) begin
                if (dq.size() == 0) begin
                    nvec++;
                    nmis++;
                    $display("FAIL dmem_spurious: got valid=1 want 0");
                end else begin
                    e = dq.pop_front();
                    if (e.chk)
                        check({e.name, "_drdata"}, bus.dmem_rdata,
                              e.rdata);
                    check({e.name, "_derr"}, 32'(bus.dmem_err),
                          32'(e.err));
                end
            end
        end
    end

    initial begin
        vec_t v;

        tbl[0]  = '{1, 32'h8000_0000, 32'h0badcfb7, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, "fetch0"};
        tbl[1]  = '{1, 32'h8000_0004, 32'h0def8f93, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, "fetch1"};
        tbl[2]  = '{1, 32'h8000_0008, 32'h340f9073, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, "fetch2"};
        tbl[3]  = '{1, 32'h8000_000C, 32'h340fe0f3, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, "fetch3"};
        tbl[4]  = '{0, 0, 0, 0, 1, 0, 32'h8000_0080, 4'hf, 0,
                    32'h01010101, 0, 1, "lw_line8"};
        tbl[5]  = '{0, 0, 0, 0, 1, 0, 32'h8000_1080, 4'hf, 0,
                    32'hABABABAB, 0, 1, "lw_line264"};
        tbl[6]  = '{0, 0, 0, 0, 1, 1, 32'h8000_0101, 4'b0010,
                    32'h0000_0100, 0, 0, 0, "sb_merge"};
        tbl[7]  = '{1, 32'h8000_0040, 32'h11223344, 0,
                    1, 1, 32'h8000_0040, 4'hf, 32'hDEADBEEF,
                    0, 0, 0, "collide"};
        tbl[8]  = '{0, 0, 0, 0, 1, 0, 32'h8000_0040, 4'hf, 0,
                    32'hDEADBEEF, 0, 1, "lw_after_sw"};
        tbl[9]  = '{0, 0, 0, 0, 1, 0, 32'h0000_0010, 4'hf, 0,
                    32'h0, 1, 1, "lw_oor"};
        tbl[10] = '{0, 0, 0, 0, 1, 1, 32'h9000_0000, 4'hf,
                    32'h55555555, 0, 1, 0, "sw_oor"};
        tbl[11] = '{1, 32'h8000_0084, 32'h22222222, 0,
                    1, 0, 32'h8000_0088, 4'hf, 0,
                    32'h33333333, 0, 1, "dual_rd"};
        tbl[12] = '{0, 0, 0, 0, 1, 0, 32'h8000_FFFC, 4'hf, 0,
                    32'hCAFEF00D, 0, 1, "lw_last"};
        tbl[13] = '{0, 0, 0, 0, 1, 0, 32'h8001_0000, 4'hf, 0,
                    32'h0, 1, 1, "lw_past_end"};
        tbl[14] = '{1, 32'h7FFF_FFFC, 32'h0, 1,
                    0, 0, 0, 0, 0, 0, 0, 0, "fetch_below"};

        idle();
        bus.imem_addr  = RESET_PC;
        bus.dmem_addr  = '0;
        bus.dmem_wstrb = '0;
        bus.dmem_wdata = '0;

        dut.ram.data[0]   = L0;
        dut.ram.data[4]   = L4;
        dut.ram.data[8]   = L8;
        dut.ram.data[16]  = '0;
        dut.ram.data[264] = L264;

        @(posedge clk);
        #1;
        check("rst_ivalid", 32'(bus.imem_valid), 0);
        check("rst_dvalid", 32'(bus.dmem_valid), 0);
        check("rst_ierr", 32'(bus.imem_err), 0);
        check("rst_derr", 32'(bus.dmem_err), 0);
        check("rst_irdata", bus.imem_rdata, 0);
        check("rst_drdata", bus.dmem_rdata, 0);

        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (i == 0) begin
                rst = 1'b0;
                dut.ram.data[RAM_LINES-1] = LLAST;
            end
            drive(tbl[i]);
        end
        @(negedge clk);
        idle();
        @(negedge clk);

        check128("sb_line16", dut.ram.data[16], 128'h0000_0100);
        check128("line4_after_sw", dut.ram.data[4],
                 128'hDEADBEEF);
        check128("line0_untouched", dut.ram.data[0], L0);
        check128("last_untouched", dut.ram.data[RAM_LINES-1],
                 LLAST);
        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);

        // Reset arriving while a load response is on the bus.
        @(negedge clk);
        v = '{0, 0, 0, 0, 1, 0, 32'h8000_0080, 4'hf, 0,
              32'h01010101, 0, 1, "lw_pre_rst"};
        drive(v);
        @(posedge clk);
        #3;
        check("dvalid_before_rst", 32'(bus.dmem_valid), 1);
        rst = 1'b1;
        #1;
        check("dvalid_async_rst", 32'(bus.dmem_valid), 0);
        check("drdata_async_rst", bus.dmem_rdata, 0);
        idle();
        bus.imem_addr = RESET_PC;
        @(posedge clk);
        #1;
        check("dvalid_in_rst", 32'(bus.dmem_valid), 0);
        check("ivalid_in_rst", 32'(bus.imem_valid), 0);
        check128("line16_kept", dut.ram.data[16], 128'h0000_0100);
        check128("line4_kept", dut.ram.data[4], 128'hDEADBEEF);

        @(negedge clk);
        rst = 1'b0;
        v = '{1, RESET_PC, 32'h0badcfb7, 0,
              0, 0, 0, 0, 0, 0, 0, 0, "refetch"};
        drive(v);
        @(negedge clk);
        v = '{1, RESET_PC + 32'd4, 32'h0def8f93, 0,
              0, 0, 0, 0, 0, 0, 0, 0, "refetch1"};
        drive(v);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("iq_final", iq.size(), 0);
        check("dq_final", dq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nmis);
        $finish;
    end

endmodule

// File: doc/my_wrapper_soc.md
Name: my_wrapper_soc

Overview:
- Top-level SoC wrapper that ties the team's existing RV32 core (instance `cpu`) to a 128-bit-line on-chip RAM (instance `ram`, storage array `data`).
- Benches preload programs by writing `ram.data[]` hierarchically.
- The block owns the RAM, the instruction/data port adapters, address decode and byte-lane merge.
- The core itself (ISA incl. M, B, A-LR/SC, CSRs, exceptions) is an existing module and is not specified here.

Parameters:
- RAM_BASE, 32'h8000_0000, byte address of `ram.data[0]` bit 0.
- RAM_LINES, 4096, number of 128-bit lines (64 KiB).
- RESET_PC, 32'h8000_0000, passed to the core as its reset fetch address.

Ports:
- CLK  input  1  system clock, all logic on rising edge.
- RST  input  1  reset; one clock, reset is asynchronous and active-high.

Behaviour:
- Memory map: RAM occupies RAM_BASE .. RAM_BASE+16*RAM_LINES-1.
  - Line index = (addr-RAM_BASE)[15:4].
  - Word select = addr[3:2]; word k occupies bits [32k+31:32k].
  - Byte b of a line occupies bits [8b+7:8b] (little-endian).
  - Example: the first instruction executed is `ram.data[0][31:0]`.
- RAM storage:
  - `reg [127:0] data [0:RAM_LINES-1]` inside the `ram` instance.
  - NOT cleared by reset; contents survive RST.
  - Preload at the same time RST deasserts must be honoured.
- Instruction port (core->wrapper: imem_req, imem_addr[31:0]; wrapper->core: imem_rdata[31:0], imem_valid, imem_err):
  - Fixed 1-cycle latency.
  - A request accepted at edge N returns rdata/valid after edge N+1.
  - Never stalls; one request per cycle.
- Data port (dmem_req, dmem_we, dmem_addr[31:0], dmem_wstrb[3:0], dmem_wdata[31:0]; returns dmem_rdata[31:0], dmem_valid, dmem_err):
  - Reads: 1-cycle latency.
  - Writes: commit at the accepting edge; only the bytes selected by wstrb are updated, in the addressed word of the addressed line; the other 12+ bytes are unchanged.
  - dmem_valid also pulses for writes one cycle later.
  - Core supplies naturally aligned, lane-shifted wdata/wstrb and performs load sign/zero extension.
- Both ports are serviced in the same cycle (true dual port).
- Same-line collision (fetch and store to the same line in the same cycle): the fetch returns pre-write data.
- Out-of-range address:
  - Read returns 32'h0 with err=1 alongside valid.
  - Write is dropped with err=1.
  - The core maps err to an access fault.
- Reset, while RST is high:
  - imem_valid=0, dmem_valid=0, err=0, rdata=0.
  - Core held at RESET_PC.
  - RST asserted mid-access cancels the pending response asynchronously; a write already committed stays.
- First fetch is issued on the first rising CLK edge with RST low.

Decomposition:
- Shared package `soc_pkg`: RAM_BASE, RAM_LINES, RESET_PC, line/word index widths, and an address-in-range function.
- One sub-module, `line_ram`:
  - Dual-port 128-bit array `data`.
  - Registered 32-bit read-word mux on each port.
  - Byte-strobe write on port B.
- my_wrapper_soc instantiates `cpu` and `ram` (line_ram) plus decode/err logic.

Test Plan:
1. Reset/fetch:
   - Stimulus: RST high 10 ns, preload data[0]=128'h340fe0f3_340f9073_0def8f93_0badcfb7.
   - Required: imem_addr=0x8000_0000 during reset; after release, fetches return 0x0badcfb7, 0x0def8f93, 0x340f9073, 0x340fe0f3 on consecutive cycles.
2. Line mapping:
   - Stimulus: data[8]=32'h01010101, data[264]=32'hABABABAB; lw from 0x8000_0080 and 0x8000_1080.
   - Required: 0x01010101 and 0xABABABAB, err=0.
3. Byte write merge:
   - Stimulus: data[16]=128'h0; sb 0x01 to 0x8000_0101 (wstrb=0010).
   - Required: data[16]=128'h0000_0100, all other bytes unchanged.
4. Collision:
   - Stimulus: same cycle, fetch 0x8000_0040 and sw 0xDEADBEEF to 0x8000_0040.
   - Required: fetch returns old word; a next-cycle lw returns 0xDEADBEEF.
5. Out-of-range:
   - Stimulus: lw 0x0000_0010; sw to 0x9000_0000.
   - Required: rdata=0, err=1; no RAM line changes.
6. Reset mid-operation:
   - Stimulus: assert RST during an outstanding lw.
   - Required: dmem_valid drops immediately, RAM contents preserved, fetch restarts at 0x8000_0000.
